// File: rtl/tmds_encoder_array.sv
// Multi-lane TMDS encoder: 10-stage lookahead delay line, then a two-stage DVI 1.0 encode (E1: q_m, E2: DC balance).
// Optional macro HDMI_GUARD_EN adds HDMI video preamble and leading guard band insertion.
module tmds_encoder_array #(
    parameter int CHANNELS = 3
) (
    input  logic                   clk_pix,
    input  logic                   rst_pix,
    input  logic                   de,
    input  logic [8*CHANNELS-1:0]  din,
    input  logic [2*CHANNELS-1:0]  ctrl,
    output logic [10*CHANNELS-1:0] tmds,
    output logic                   tmds_valid
);
    localparam int DEPTH = 10;
    localparam logic [9:0] SYM_C00    = 10'b1101010100;
    localparam logic [9:0] SYM_C01    = 10'b0010101011;
    localparam logic [9:0] SYM_C10    = 10'b0101010100;
    localparam logic [9:0] SYM_C11    = 10'b1010101011;
    localparam logic [9:0] GUARD_EVEN = 10'b1011001100;
    localparam logic [9:0] GUARD_ODD  = 10'b0100110011;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    function automatic logic [9:0] ctrl_symbol(input logic [1:0] c);
        case (c)
            2'b00:   return SYM_C00;
            2'b01:   return SYM_C01;
            2'b10:   return SYM_C10;
            default: return SYM_C11;
        endcase
    endfunction

    function automatic logic [8:0] encode_qm(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] q;
        n1       = popcount8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q        = 9'd0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8]     = ~use_xnor;
        return q;
    endfunction

    // Disparity math is done modulo 32: the true result always stays inside -16..+15,
    // so the low five bits are exact without sign extension.
    function automatic logic [14:0] encode_video(input logic [8:0] qm, input logic [4:0] disp);
        logic [3:0] n1;
        logic [4:0] bal;
        logic [9:0] sym;
        logic [4:0] nxt;
        n1  = popcount8(qm[7:0]);
        bal = {n1, 1'b0} - 5'd8;
        if ((disp == 5'd0) || (n1 == 4'd4)) begin
            sym = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            nxt = qm[8] ? (disp + bal) : (disp - bal);
        end else if ((!disp[4] && (n1 > 4'd4)) || (disp[4] && (n1 < 4'd4))) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            nxt = disp + {3'b000, qm[8], 1'b0} - bal;
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            nxt = disp - {3'b000, ~qm[8], 1'b0} + bal;
        end
        return {sym, nxt};
    endfunction

    // Stage k (0-based) holds the input sampled k+1 edges ago; stage DEPTH-1 is S.
    logic [DEPTH-1:0]      de_dl_q;
    logic [8*CHANNELS-1:0] din_dl_q  [DEPTH];
    logic [2*CHANNELS-1:0] ctrl_dl_q [DEPTH];
    logic [3:0]            vcnt_q;

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            de_dl_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                din_dl_q[k]  <= '0;
                ctrl_dl_q[k] <= '0;
            end
        end else begin
            de_dl_q      <= {de_dl_q[DEPTH-2:0], de};
            din_dl_q[0]  <= din;
            ctrl_dl_q[0] <= ctrl;
            for (int k = 1; k < DEPTH; k++) begin
                din_dl_q[k]  <= din_dl_q[k-1];
                ctrl_dl_q[k] <= ctrl_dl_q[k-1];
            end
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix)                vcnt_q <= 4'd0;
        else if (vcnt_q != 4'd12)   vcnt_q <= vcnt_q + 4'd1;
    end

    assign tmds_valid = (vcnt_q == 4'd12);

    logic guard;
    logic preamble;
`ifdef HDMI_GUARD_EN
    // S still carries reset contents until ten post-reset edges have passed; no
    // preamble or guard may be built on top of those slots.
    logic s_live;
    assign s_live   = (vcnt_q >= 4'd10);
    assign guard    = s_live && !de_dl_q[DEPTH-1] && (de_dl_q[DEPTH-2] || de_dl_q[DEPTH-3]);
    assign preamble = s_live && !de_dl_q[DEPTH-1] && !guard && (|{de_dl_q[DEPTH-4:0], de});
`else
    assign guard    = 1'b0;
    assign preamble = 1'b0;
`endif

    logic [8:0] qm_d  [CHANNELS];
    logic [8:0] qm_q  [CHANNELS];
    logic [9:0] sym_d [CHANNELS];
    logic [9:0] sym_q [CHANNELS];
    logic       vid_q;
    logic [1:0] lane_ctrl;

    always_comb begin
        lane_ctrl = 2'b00;
        for (int l = 0; l < CHANNELS; l++) begin
            qm_d[l]   = encode_qm(din_dl_q[DEPTH-1][8*l +: 8]);
            lane_ctrl = ctrl_dl_q[DEPTH-1][2*l +: 2];
            if (preamble && (l == 1)) lane_ctrl = 2'b01;
            if (preamble && (l == 2)) lane_ctrl = 2'b00;
            if (guard) sym_d[l] = ((l % 2) == 0) ? GUARD_EVEN : GUARD_ODD;
            else       sym_d[l] = ctrl_symbol(lane_ctrl);
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            vid_q <= 1'b0;
            for (int l = 0; l < CHANNELS; l++) begin
                qm_q[l]  <= 9'd0;
                sym_q[l] <= SYM_C00;
            end
        end else begin
            vid_q <= de_dl_q[DEPTH-1];
            qm_q  <= qm_d;
            sym_q <= sym_d;
        end
    end

    logic [10*CHANNELS-1:0] tmds_d;
    logic [10*CHANNELS-1:0] tmds_q;
    logic [4:0]             disp_d [CHANNELS];
    logic [4:0]             disp_q [CHANNELS];
    logic [14:0]            enc;

    always_comb begin
        tmds_d = '0;
        enc    = 15'd0;
        for (int l = 0; l < CHANNELS; l++) begin
            disp_d[l] = 5'd0;
            if (vid_q) begin
                enc                 = encode_video(qm_q[l], disp_q[l]);
                tmds_d[10*l +: 10]  = enc[14:5];
                disp_d[l]           = enc[4:0];
            end else begin
                tmds_d[10*l +: 10]  = sym_q[l];
            end
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            tmds_q <= {CHANNELS{SYM_C00}};
            for (int l = 0; l < CHANNELS; l++) disp_q[l] <= 5'd0;
        end else begin
            tmds_q <= tmds_d;
            disp_q <= disp_d;
        end
    end

    assign tmds = tmds_q;

endmodule

// File: tb/tb_tmds_encoder_array.sv
// Directed bench for tmds_encoder_array (CHANNELS=3); expectations follow HDMI_GUARD_EN when defined.
module tb_tmds_encoder_array;
    localparam int CH = 3;
    localparam logic [9:0] C00 = 10'b1101010100;
    localparam logic [9:0] C01 = 10'b0010101011;
    localparam logic [9:0] C10 = 10'b0101010100;
    localparam logic [9:0] C11 = 10'b1010101011;
`ifdef HDMI_GUARD_EN
    localparam logic [9:0] GE  = 10'b1011001100;
    localparam logic [9:0] GO  = 10'b0100110011;
`endif

    logic              clk_pix = 1'b0;
    logic              rst_pix;
    logic              de;
    logic [8*CH-1:0]   din;
    logic [2*CH-1:0]   ctrl;
    logic [10*CH-1:0]  tmds;
    logic              tmds_valid;
    int                n_checks = 0;
    int                n_fail   = 0;

    tmds_encoder_array #(.CHANNELS(CH)) dut (
        .clk_pix    (clk_pix),
        .rst_pix    (rst_pix),
        .de         (de),
        .din        (din),
        .ctrl       (ctrl),
        .tmds       (tmds),
        .tmds_valid (tmds_valid)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic step();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic drive(input logic d, input logic [8*CH-1:0] px, input logic [2*CH-1:0] c);
        de   = d;
        din  = px;
        ctrl = c;
    endtask

    task automatic test_reset();
        logic exp_v;
        rst_pix = 1'b1;
        drive(1'b0, '0, '0);
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (tmds !== {CH{C00}}) begin
                n_fail++;
                $display("FAIL reset_tmds: got %h expected %h", tmds, {CH{C00}});
            end
            n_checks++;
            if (tmds_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_valid: got %b expected 0", tmds_valid);
            end
        end
        rst_pix = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_v = (k == 12);
            n_checks++;
            if (tmds_valid !== exp_v) begin
                n_fail++;
                $display("FAIL valid_rise edge %0d: got %b expected %b", k, tmds_valid, exp_v);
            end
            n_checks++;
            if (tmds !== {CH{C00}}) begin
                n_fail++;
                $display("FAIL post_reset_tmds edge %0d: got %h expected %h", k, tmds, {CH{C00}});
            end
        end
    endtask

    task automatic test_control_map();
        logic [2*CH-1:0]  cv [4];
        logic [10*CH-1:0] ev [4];
        cv[0] = {2'b10, 2'b01, 2'b00}; ev[0] = {C10, C01, C00};
        cv[1] = {2'b11, 2'b10, 2'b01}; ev[1] = {C11, C10, C01};
        cv[2] = {2'b00, 2'b11, 2'b10}; ev[2] = {C00, C11, C10};
        cv[3] = {2'b01, 2'b00, 2'b11}; ev[3] = {C01, C00, C11};
        for (int j = 0; j < 4 + 11; j++) begin
            if (j < 4) drive(1'b0, '0, cv[j]);
            else       drive(1'b0, '0, '0);
            step();
            if (j >= 11) begin
                n_checks++;
                if (tmds !== ev[j-11]) begin
                    n_fail++;
                    $display("FAIL control_map vec %0d: got %h expected %h", j - 11, tmds, ev[j-11]);
                end
            end
        end
    endtask

    task automatic test_disparity();
        logic             dv [5];
        logic [10*CH-1:0] ev [5];
        logic [10*CH-1:0] blank_sym;
`ifdef HDMI_GUARD_EN
        blank_sym = {GE, GO, GE};
`else
        blank_sym = {CH{C00}};
`endif
        dv[0] = 1'b0; ev[0] = blank_sym;
        dv[1] = 1'b1; ev[1] = {CH{10'h100}};
        dv[2] = 1'b1; ev[2] = {CH{10'h3FF}};
        dv[3] = 1'b0; ev[3] = blank_sym;
        dv[4] = 1'b1; ev[4] = {CH{10'h100}};
        for (int j = 0; j < 5 + 11; j++) begin
            if (j < 5) drive(dv[j], '0, '0);
            else       drive(1'b0, '0, '0);
            step();
            if (j >= 11) begin
                n_checks++;
                if (tmds !== ev[j-11]) begin
                    n_fail++;
                    $display("FAIL disparity vec %0d: got %h expected %h", j - 11, tmds, ev[j-11]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [10*CH-1:0] ev [5];
`ifdef HDMI_GUARD_EN
        ev[0] = {GE, GO, GE};
`else
        ev[0] = {CH{C00}};
`endif
        ev[1] = {10'h133, 10'h100, 10'h200};
        ev[2] = {10'h133, 10'h3FF, 10'h0FF};
        ev[3] = {10'h133, 10'h100, 10'h0FF};
        ev[4] = {10'h133, 10'h3FF, 10'h200};
        for (int j = 0; j < 5 + 11; j++) begin
            if ((j >= 1) && (j < 5)) drive(1'b1, 24'h5500FF, '0);
            else                     drive(1'b0, '0, '0);
            step();
            if (j >= 11) begin
                n_checks++;
                if (tmds !== ev[j-11]) begin
                    n_fail++;
                    $display("FAIL back_to_back vec %0d: got %h expected %h", j - 11, tmds, ev[j-11]);
                end
            end
        end
        n_checks++;
        if (tmds_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL valid_saturated: got %b expected 1", tmds_valid);
        end
    endtask

    task automatic test_guard_preamble();
        logic [10*CH-1:0] exp_t;
        for (int j = 0; j < 21 + 11; j++) begin
            if (j == 20) drive(1'b1, '0, '0);
            else         drive(1'b0, '0, '0);
            step();
            if (j >= 11 + 8) begin
                exp_t = {CH{C00}};
                if (j - 11 == 20) exp_t = {CH{10'h100}};
`ifdef HDMI_GUARD_EN
                if ((j - 11 >= 10) && (j - 11 <= 17)) exp_t = {C00, C01, C00};
                if ((j - 11 >= 18) && (j - 11 <= 19)) exp_t = {GE, GO, GE};
`endif
                n_checks++;
                if (tmds !== exp_t) begin
                    n_fail++;
                    $display("FAIL guard_preamble vec %0d: got %h expected %h", j - 11, tmds, exp_t);
                end
            end
        end
    endtask

    task automatic test_short_blank();
        logic [10*CH-1:0] ev [4];
        ev[0] = {CH{10'h133}};
`ifdef HDMI_GUARD_EN
        ev[1] = {GE, GO, GE};
`else
        ev[1] = {CH{C00}};
`endif
        ev[2] = {CH{10'h133}};
        ev[3] = {CH{C00}};
        for (int j = 0; j < 4 + 11; j++) begin
            if ((j == 0) || (j == 2)) drive(1'b1, {CH{8'h55}}, '0);
            else                      drive(1'b0, '0, '0);
            step();
            if (j >= 11) begin
                n_checks++;
                if (tmds !== ev[j-11]) begin
                    n_fail++;
                    $display("FAIL short_blank vec %0d: got %h expected %h", j - 11, tmds, ev[j-11]);
                end
            end
        end
    endtask

    task automatic test_midframe_reset();
        logic             exp_v;
        logic [10*CH-1:0] exp_t;
        drive(1'b1, {CH{8'hFF}}, '0);
        for (int j = 0; j < 14; j++) step();
        rst_pix = 1'b1;
        step();
        n_checks++;
        if (tmds !== {CH{C00}}) begin
            n_fail++;
            $display("FAIL midframe_reset_tmds: got %h expected %h", tmds, {CH{C00}});
        end
        n_checks++;
        if (tmds_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_reset_valid: got %b expected 0", tmds_valid);
        end
        rst_pix = 1'b0;
        drive(1'b1, '0, '0);
        for (int k = 1; k <= 13; k++) begin
            step();
            exp_v = (k >= 12);
            exp_t = {CH{C00}};
            if (k == 12) exp_t = {CH{10'h100}};
            if (k == 13) exp_t = {CH{10'h3FF}};
            n_checks++;
            if (tmds !== exp_t) begin
                n_fail++;
                $display("FAIL restart_tmds edge %0d: got %h expected %h", k, tmds, exp_t);
            end
            n_checks++;
            if (tmds_valid !== exp_v) begin
                n_fail++;
                $display("FAIL restart_valid edge %0d: got %b expected %b", k, tmds_valid, exp_v);
            end
        end
    endtask

    initial begin
        rst_pix = 1'b1;
        drive(1'b0, '0, '0);
        test_reset();
        test_control_map();
        test_disparity();
        test_back_to_back();
        test_guard_preamble();
        test_short_blank();
        test_midframe_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
